// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel plus the
// decode-side handoff. The fetch unit takes the master view.
interface instr_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_fault;
    logic        id_ready;

    modport master (
        output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, if_fault,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, if_fault,
        output imem_req_ready, imem_resp_valid, imem_resp_data, id_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one imem read per PC value, results buffered with their PC in a small FIFO.
// Optional FETCH_MISALIGN_TRAP_EN turns misaligned PCs into fault entries and halts fetch.
module instr_fetch_unit #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        pc_in,
    input  logic               redirect,
    output logic               pc_inc_en,
    instr_fetch_unit_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HALT} state_t;

    state_t           state;
    logic             drop;
    logic [31:0]      req_pc;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [31:0] pc_mem    [FIFO_DEPTH];
    logic [31:0] instr_mem [FIFO_DEPTH];
    logic        fault_mem [FIFO_DEPTH];

    logic        has_space;
    logic        misaligned;
    logic [31:0] fetch_addr;
    logic        req_fire;
    logic        trap;
    logic        resp_push;
    logic        push;
    logic        pop;
    logic        head_valid;
    logic [31:0] push_pc;
    logic [31:0] push_instr;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misaligned = (pc_in[1:0] != 2'b00);
    assign fetch_addr = pc_in;
`else
    assign misaligned = 1'b0;
    assign fetch_addr = {pc_in[31:2], 2'b00};
`endif

    // A redirect cycle never issues: pc_in is about to change under the request.
    assign has_space          = (count < FULL_CNT);
    assign bus.imem_req_valid = (state == REQ) && has_space && !redirect && !misaligned;
    assign bus.imem_req_addr  = (state == REQ) ? fetch_addr : 32'h0;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
    assign pc_inc_en          = req_fire;

    assign trap       = (state == REQ) && has_space && !redirect && misaligned;
    assign resp_push  = (state == WAIT) && bus.imem_resp_valid && !drop && !redirect;
    assign push       = resp_push || trap;
    assign push_pc    = trap ? pc_in : req_pc;
    assign push_instr = trap ? NOP_INSTR : bus.imem_resp_data;

    assign head_valid   = (count != '0);
    assign pop          = head_valid && bus.id_ready;
    assign bus.if_valid = head_valid;
    assign bus.if_pc    = head_valid ? pc_mem[rd_ptr] : 32'h0;
    assign bus.if_instr = head_valid ? instr_mem[rd_ptr] : 32'h0;
    assign bus.if_fault = head_valid && fault_mem[rd_ptr];

    // NOTE: all state below uses non-blocking assignments so every read in this
    // block sees the pre-edge value, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            drop   <= 1'b0;
            req_pc <= 32'h0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (req_fire) begin
                        req_pc <= pc_in;
                        state  <= WAIT;
                    end else if (trap) begin
                        state <= HALT;
                    end
                end
                WAIT: begin
                    if (bus.imem_resp_valid) begin
                        state <= REQ;
                        drop  <= 1'b0;
                    end else if (redirect) begin
                        drop <= 1'b1;
                    end
                end
                HALT: if (redirect) state <= REQ;
            endcase

            // Redirect flushes the buffer and wins over any same-edge push or pop.
            if (redirect) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // NOTE: payload storage is deliberately not reset; head_valid gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= push_pc;
            instr_mem[wr_ptr] <= push_instr;
            fault_mem[wr_ptr] <= trap;
        end
    end
endmodule
